ae350_rst_seq: RTL and testbench

- Reset/bring-up sequencer for the AE350 SoC top.
- Qualifies PLL lock, releases the DDR3 controller reset, waits for DDR3 calibration (init), then releases POR_RSTN and HW_RSTN to the SoC in order.
- Monitors lock loss and a debounced user reset key, and re-runs the sequence when either occurs.
- Sits between the PLL/DDR3 status signals and the SoC reset inputs.

---
 rtl/ae350_rst_pkg.sv | 30 +++
 rtl/ae350_key_dbnc.sv | 44 ++++
 rtl/ae350_rst_seq.sv | 215 +++++++++++++++++++++
 tb/tb_ae350_rst_seq.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ae350_rst_pkg.sv
// Shared state encoding, default cycle counts and counter sizing for the AE350 reset sequencer.
package ae350_rst_pkg;

  typedef enum logic [2:0] {
    StWaitLock = 3'd0,
    StDdrRel   = 3'd1,
    StWaitInit = 3'd2,
    StPorDly   = 3'd3,
    StHwDly    = 3'd4,
    StRun      = 3'd5,
    StError    = 3'd6
  } seq_state_e;

  localparam int unsigned DefLockStableCyc = 1024;
  localparam int unsigned DefPorDlyCyc     = 256;
  localparam int unsigned DefHwDlyCyc      = 64;
  localparam int unsigned DefDbncCyc       = 50000;
  localparam int unsigned DefDdrTmoCyc     = 1048576;
  localparam int unsigned DefMaxRetry      = 3;
  localparam int unsigned TmoPulseCyc      = 16;

  function automatic int unsigned cnt_width(input int unsigned cyc);
    return $clog2(cyc) + 1;
  endfunction

  function automatic int unsigned max_cyc(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ae350_key_dbnc.sv
// User reset key debouncer: one registered pulse per sufficiently long low press.
module ae350_key_dbnc
  import ae350_rst_pkg::*;
#(
  parameter int unsigned DBNC_CYC = DefDbncCyc
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_key_rstn,
  output logic o_key_pulse,
  output logic o_key_held
);

  localparam int unsigned     CntW   = cnt_width(DBNC_CYC);
  localparam logic [CntW-1:0] CntHit = CntW'(DBNC_CYC - 1);

  logic [CntW-1:0] r_cnt;
  logic            r_pulse;
  logic            r_fired;
  logic            w_hit;

  // r_fired blocks a second pulse until the key is seen high again
  assign w_hit = !i_key_rstn && (r_cnt == CntHit) && !r_fired;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_cnt   <= '0;
      r_pulse <= 1'b0;
      r_fired <= 1'b0;
    end else if (i_key_rstn) begin
      r_cnt   <= '0;
      r_pulse <= 1'b0;
      r_fired <= 1'b0;
    end else begin
      if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
      r_pulse <= w_hit;
      if (w_hit) r_fired <= 1'b1;
    end
  end

  assign o_key_pulse = r_pulse;
  assign o_key_held  = r_fired;

endmodule

// File: rtl/ae350_rst_seq.sv
// AE350 reset/bring-up sequencer: lock qualify, DDR3 release and calibration, then POR/HW release.
// Build option AE350_RST_SEQ_DDR_TMO_EN adds a DDR3 init timeout with retries and an ERROR state.
module ae350_rst_seq
  import ae350_rst_pkg::*;
#(
  parameter int unsigned LOCK_STABLE_CYC = DefLockStableCyc,
  parameter int unsigned POR_DLY_CYC     = DefPorDlyCyc,
  parameter int unsigned HW_DLY_CYC      = DefHwDlyCyc,
`ifdef AE350_RST_SEQ_DDR_TMO_EN
  parameter int unsigned DDR_TMO_CYC     = DefDdrTmoCyc,
  parameter int unsigned MAX_RETRY       = DefMaxRetry,
`endif
  parameter int unsigned DBNC_CYC        = DefDbncCyc
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_pll_lock,
  input  logic       i_ddr3_lock,
  input  logic       i_ddr3_init,
  input  logic       i_key_rstn,
  output logic       o_ddr3_rstn,
  output logic       o_por_rstn,
  output logic       o_hw_rstn,
  output logic [2:0] o_seq_state,
  output logic       o_seq_err
);

`ifdef AE350_RST_SEQ_DDR_TMO_EN
  localparam int unsigned MaxCyc = max_cyc(max_cyc(LOCK_STABLE_CYC, POR_DLY_CYC),
                                           max_cyc(max_cyc(HW_DLY_CYC, DDR_TMO_CYC), TmoPulseCyc));
`else
  localparam int unsigned MaxCyc = max_cyc(max_cyc(LOCK_STABLE_CYC, POR_DLY_CYC), HW_DLY_CYC);
`endif
  localparam int unsigned     CntW    = cnt_width(MaxCyc);
  localparam logic [CntW-1:0] LockHit = CntW'(LOCK_STABLE_CYC - 1);
  localparam logic [CntW-1:0] PorHit  = CntW'(POR_DLY_CYC - 1);
  localparam logic [CntW-1:0] HwHit   = CntW'(HW_DLY_CYC - 1);
`ifdef AE350_RST_SEQ_DDR_TMO_EN
  localparam int unsigned       RetryW   = cnt_width(MAX_RETRY);
  localparam logic [CntW-1:0]   TmoHit   = CntW'(DDR_TMO_CYC - 1);
  // The DDR_REL cycle that follows supplies the last low cycle of the pulse
  localparam logic [CntW-1:0]   PulseHit = CntW'(TmoPulseCyc - 2);
  localparam logic [RetryW-1:0] RetryMax = RetryW'(MAX_RETRY);
`endif

  seq_state_e      r_state, w_state_d;
  logic [CntW-1:0] r_cnt, w_cnt_d, w_cnt_inc;
  logic            r_ddr3_rstn, w_ddr3_rstn_d;
  logic            r_por_rstn, w_por_rstn_d;
  logic            r_hw_rstn, w_hw_rstn_d;
  logic            w_lock_ok, w_key_pulse, w_key_held, w_init_req, w_abort;
`ifdef AE350_RST_SEQ_DDR_TMO_EN
  logic              r_seq_err, w_seq_err_d;
  logic              r_tmo_pulse, w_tmo_pulse_d;
  logic [RetryW-1:0] r_retry, w_retry_d;
`endif

  ae350_key_dbnc #(
    .DBNC_CYC(DBNC_CYC)
  ) u_key_dbnc (
    .i_clk      (i_clk),
    .i_rstn     (i_rstn),
    .i_key_rstn (i_key_rstn),
    .o_key_pulse(w_key_pulse),
    .o_key_held (w_key_held)
  );

  assign w_lock_ok  = i_pll_lock && i_ddr3_lock;
  assign w_cnt_inc  = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
  assign w_init_req = (r_state == StPorDly) || (r_state == StHwDly) || (r_state == StRun);
  assign w_abort    = (r_state != StWaitLock) && (r_state != StError) &&
                      (!w_lock_ok || w_key_pulse || (w_init_req && !i_ddr3_init));

  always_comb begin
    w_state_d     = r_state;
    w_cnt_d       = r_cnt;
    w_ddr3_rstn_d = r_ddr3_rstn;
    w_por_rstn_d  = r_por_rstn;
    w_hw_rstn_d   = r_hw_rstn;
`ifdef AE350_RST_SEQ_DDR_TMO_EN
    w_seq_err_d   = r_seq_err;
    w_tmo_pulse_d = r_tmo_pulse;
    w_retry_d     = r_retry;
`endif
    if (w_abort) begin
      w_state_d     = StWaitLock;
      w_cnt_d       = '0;
      w_ddr3_rstn_d = 1'b0;
      w_por_rstn_d  = 1'b0;
      w_hw_rstn_d   = 1'b0;
`ifdef AE350_RST_SEQ_DDR_TMO_EN
      w_tmo_pulse_d = 1'b0;
`endif
    end else begin
      case (r_state)
        StWaitLock: begin
          if (!w_lock_ok || w_key_held || w_key_pulse) begin
            w_cnt_d = '0;
          end else if (r_cnt == LockHit) begin
            w_state_d = StDdrRel;
            w_cnt_d   = '0;
          end else begin
            w_cnt_d = w_cnt_inc;
          end
        end
        StDdrRel: begin
          w_ddr3_rstn_d = 1'b1;
          w_state_d     = StWaitInit;
        end
        StWaitInit: begin
`ifdef AE350_RST_SEQ_DDR_TMO_EN
          if (r_tmo_pulse) begin
            if (r_cnt == PulseHit) begin
              w_tmo_pulse_d = 1'b0;
              w_state_d     = StDdrRel;
              w_cnt_d       = '0;
            end else begin
              w_cnt_d = w_cnt_inc;
            end
          end else if (i_ddr3_init) begin
            w_state_d = StPorDly;
            w_cnt_d   = '0;
          end else if (r_cnt == TmoHit) begin
            w_cnt_d       = '0;
            w_ddr3_rstn_d = 1'b0;
            if (r_retry == RetryMax) begin
              w_state_d   = StError;
              w_seq_err_d = 1'b1;
            end else begin
              w_retry_d     = r_retry + 1'b1;
              w_tmo_pulse_d = 1'b1;
            end
          end else begin
            w_cnt_d = w_cnt_inc;
          end
`else
          if (i_ddr3_init) begin
            w_state_d = StPorDly;
            w_cnt_d   = '0;
          end
`endif
        end
        StPorDly: begin
          if (r_cnt == PorHit) begin
            w_por_rstn_d = 1'b1;
            w_state_d    = StHwDly;
            w_cnt_d      = '0;
          end else begin
            w_cnt_d = w_cnt_inc;
          end
        end
        StHwDly: begin
          if (r_cnt == HwHit) begin
            w_hw_rstn_d = 1'b1;
            w_state_d   = StRun;
            w_cnt_d     = '0;
`ifdef AE350_RST_SEQ_DDR_TMO_EN
            w_retry_d   = '0;
`endif
          end else begin
            w_cnt_d = w_cnt_inc;
          end
        end
        StRun: ;
`ifdef AE350_RST_SEQ_DDR_TMO_EN
        StError: ;
`endif
        default: begin
          w_state_d     = StWaitLock;
          w_cnt_d       = '0;
          w_ddr3_rstn_d = 1'b0;
          w_por_rstn_d  = 1'b0;
          w_hw_rstn_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_state     <= StWaitLock;
      r_cnt       <= '0;
      r_ddr3_rstn <= 1'b0;
      r_por_rstn  <= 1'b0;
      r_hw_rstn   <= 1'b0;
`ifdef AE350_RST_SEQ_DDR_TMO_EN
      r_seq_err   <= 1'b0;
      r_tmo_pulse <= 1'b0;
      r_retry     <= '0;
`endif
    end else begin
      r_state     <= w_state_d;
      r_cnt       <= w_cnt_d;
      r_ddr3_rstn <= w_ddr3_rstn_d;
      r_por_rstn  <= w_por_rstn_d;
      r_hw_rstn   <= w_hw_rstn_d;
`ifdef AE350_RST_SEQ_DDR_TMO_EN
      r_seq_err   <= w_seq_err_d;
      r_tmo_pulse <= w_tmo_pulse_d;
      r_retry     <= w_retry_d;
`endif
    end
  end

  assign o_ddr3_rstn = r_ddr3_rstn;
  assign o_por_rstn  = r_por_rstn;
  assign o_hw_rstn   = r_hw_rstn;
  assign o_seq_state = r_state;
`ifdef AE350_RST_SEQ_DDR_TMO_EN
  assign o_seq_err   = r_seq_err;
`else
  assign o_seq_err   = 1'b0;
`endif

endmodule

// File: tb/tb_ae350_rst_seq.sv
// Bench for ae350_rst_seq: directed bring-up/abort scenarios, then randomized inputs vs a cycle model.
// Define AE350_RST_SEQ_DDR_TMO_EN to also cover the DDR3 init timeout/retry path.
module tb_ae350_rst_seq;

  localparam int LockCyc  = 8;
  localparam int PorCyc   = 4;
  localparam int HwCyc    = 2;
  localparam int DbncCyc  = 5;
`ifdef AE350_RST_SEQ_DDR_TMO_EN
  localparam int TmoCyc   = 20;
  localparam int MaxRetry = 2;
  localparam int PulseCyc = 16;
`endif

  logic       clk = 1'b0;
  logic       rstn, pll, dl, init, key;
  logic       ddr3, por, hw, err;
  logic [2:0] state;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: what each output should hold after the most recent clock edge
  int m_state = 0, m_elapsed = 0, m_low_run = 0;
  bit m_ddr = 0, m_por = 0, m_hw = 0, m_err = 0, m_pulse = 0, m_held = 0;
`ifdef AE350_RST_SEQ_DDR_TMO_EN
  int m_retry = 0;
  bit m_in_pulse = 0;
`endif

  always #5 clk = ~clk;

  ae350_rst_seq #(
    .LOCK_STABLE_CYC(LockCyc),
    .POR_DLY_CYC    (PorCyc),
    .HW_DLY_CYC     (HwCyc),
`ifdef AE350_RST_SEQ_DDR_TMO_EN
    .DDR_TMO_CYC    (TmoCyc),
    .MAX_RETRY      (MaxRetry),
`endif
    .DBNC_CYC       (DbncCyc)
  ) dut (
    .i_clk      (clk),
    .i_rstn     (rstn),
    .i_pll_lock (pll),
    .i_ddr3_lock(dl),
    .i_ddr3_init(init),
    .i_key_rstn (key),
    .o_ddr3_rstn(ddr3),
    .o_por_rstn (por),
    .o_hw_rstn  (hw),
    .o_seq_state(state),
    .o_seq_err  (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic enter(input int s);
    m_state   = s;
    m_elapsed = 0;
  endtask

  task automatic init_wait();
`ifdef AE350_RST_SEQ_DDR_TMO_EN
    if (m_in_pulse) begin
      m_elapsed++;
      // the following DDR_REL cycle is the last low cycle of the pulse
      if (m_elapsed == PulseCyc - 1) begin
        m_in_pulse = 0;
        enter(1);
      end
    end else if (init) begin
      enter(3);
    end else begin
      m_elapsed++;
      if (m_elapsed == TmoCyc) begin
        m_elapsed = 0;
        m_ddr     = 0;
        if (m_retry == MaxRetry) begin
          m_state = 6;
          m_err   = 1;
        end else begin
          m_retry++;
          m_in_pulse = 1;
        end
      end
    end
`else
    if (init) enter(3);
`endif
  endtask

  task automatic model_edge();
    bit locks, abort;
    if (!rstn) begin
      m_state = 0; m_elapsed = 0; m_ddr = 0; m_por = 0; m_hw = 0; m_err = 0;
      m_low_run = 0; m_pulse = 0; m_held = 0;
`ifdef AE350_RST_SEQ_DDR_TMO_EN
      m_retry = 0; m_in_pulse = 0;
`endif
      return;
    end
    locks = pll && dl;
    abort = (m_state != 0) && (m_state != 6) &&
            (!locks || m_pulse || (m_state >= 3 && !init));
    if (abort) begin
      m_state = 0; m_elapsed = 0; m_ddr = 0; m_por = 0; m_hw = 0;
`ifdef AE350_RST_SEQ_DDR_TMO_EN
      m_in_pulse = 0;
`endif
    end else begin
      case (m_state)
        0: begin
          m_elapsed = (locks && !m_held && !m_pulse) ? m_elapsed + 1 : 0;
          if (m_elapsed == LockCyc) enter(1);
        end
        1: begin
          m_ddr = 1;
          enter(2);
        end
        2: init_wait();
        3: begin
          m_elapsed++;
          if (m_elapsed == PorCyc) begin m_por = 1; enter(4); end
        end
        4: begin
          m_elapsed++;
          if (m_elapsed == HwCyc) begin
            m_hw = 1;
`ifdef AE350_RST_SEQ_DDR_TMO_EN
            m_retry = 0;
`endif
            enter(5);
          end
        end
        default: ;
      endcase
    end
    // a press registers on exactly its DbncCyc-th consecutive low sample
    m_low_run = key ? 0 : m_low_run + 1;
    m_pulse   = (m_low_run == DbncCyc);
    m_held    = (m_low_run >= DbncCyc);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    check("seq_state", 32'(state), 32'(m_state));
    check("ddr3_rstn", 32'(ddr3), 32'(m_ddr));
    check("por_rstn", 32'(por), 32'(m_por));
    check("hw_rstn", 32'(hw), 32'(m_hw));
    check("seq_err", 32'(err), 32'(m_err));
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
  endtask

  initial begin
    int n, width, pulses, key_len;
    rstn = 1'b0; pll = 1'b1; dl = 1'b1; init = 1'b0; key = 1'b1;
    #2;

    // Reset values
    tick();
    tick();
    check("reset_state", 32'(state), 32'd0);
    check("reset_ddr3", 32'(ddr3), 32'd0);
    check("reset_por", 32'(por), 32'd0);
    check("reset_hw", 32'(hw), 32'd0);
    check("reset_err", 32'(err), 32'd0);

    // 1: nominal bring-up
    rstn = 1'b1;
    n = 0;
    while (ddr3 !== 1'b1 && n < 40) begin tick(); n++; end
    check("t1_ddr3_latency", n, LockCyc + 1);
    repeat (9) tick();
    init = 1'b1;
    n = 0;
    while (por !== 1'b1 && n < 20) begin tick(); n++; end
    check("t1_por_latency", n, PorCyc + 1);
    n = 0;
    while (hw !== 1'b1 && n < 20) begin tick(); n++; end
    check("t1_hw_latency", n, HwCyc);
    check("t1_run", 32'(state), 32'd5);

    // 2: one-cycle PLL glitch at lock count 6 restarts the qualification
    init = 1'b0;
    do_reset();
    n = 0;
    repeat (6) begin tick(); n++; end
    pll = 1'b0;
    tick(); n++;
    pll = 1'b1;
    while (ddr3 !== 1'b1 && n < 60) begin tick(); n++; end
    check("t2_ddr3_latency", n, (LockCyc + 1) + 7);
    init = 1'b1;
    n = 0;
    while (state !== 3'd5 && n < 30) begin tick(); n++; end
    check("t2_run", 32'(state), 32'd5);

    // 3: lock loss in RUN, then full re-run
    dl = 1'b0;
    tick();
    check("t3_state", 32'(state), 32'd0);
    check("t3_resets", 32'({ddr3, por, hw}), 32'd0);
    dl = 1'b1;
    n = 0;
    while (state !== 3'd5 && n < 40) begin tick(); n++; end
    check("t3_rerun", 32'(state), 32'd5);

    // 4: key debounce
    key = 1'b0;
    repeat (DbncCyc - 1) tick();
    key = 1'b1;
    repeat (3) tick();
    check("t4_short_press", 32'(state), 32'd5);
    key = 1'b0;
    repeat (DbncCyc + 1) tick();
    check("t4_abort", 32'(state), 32'd0);
    check("t4_abort_resets", 32'({ddr3, por, hw}), 32'd0);
    repeat (20) tick();
    check("t4_held", 32'(state), 32'd0);
    key = 1'b1;
    n = 0;
    while (state !== 3'd5 && n < 40) begin tick(); n++; end
    check("t4_release", 32'(state), 32'd5);

    // 6: RSTN mid-POR_DLY
    do_reset();
    n = 0;
    while (state !== 3'd3 && n < 30) begin tick(); n++; end
    tick();
    rstn = 1'b0;
    tick();
    check("t6_state", 32'(state), 32'd0);
    check("t6_resets", 32'({ddr3, por, hw}), 32'd0);
    check("t6_err", 32'(err), 32'd0);
    rstn = 1'b1;

`ifdef AE350_RST_SEQ_DDR_TMO_EN
    // 5: DDR3 init never completes
    init = 1'b0;
    do_reset();
    n = 0;
    while (ddr3 !== 1'b1 && n < 40) begin tick(); n++; end
    width = 0; pulses = 0; n = 0;
    while (state !== 3'd6 && n < 400) begin
      tick(); n++;
      if (ddr3 === 1'b0) width++;
      else if (width != 0) begin
        check("t5_pulse_width", width, PulseCyc);
        pulses++;
        width = 0;
      end
    end
    check("t5_pulses", pulses, MaxRetry);
    check("t5_state", 32'(state), 32'd6);
    check("t5_err", 32'(err), 32'd1);
    for (int i = 0; i < 24; i++) begin
      pll = i[0];
      dl  = i[1];
      tick();
    end
    pll = 1'b1; dl = 1'b1;
    check("t5_hold_state", 32'(state), 32'd6);
    check("t5_hold_err", 32'(err), 32'd1);
    rstn = 1'b0;
    tick();
    check("t5_clear_err", 32'(err), 32'd0);
    rstn = 1'b1;
`endif

    // Randomized inputs against the model
    do_reset();
    key_len = 0;
    for (int i = 0; i < 3000; i++) begin
      rstn = ($urandom_range(0, 199) != 0);
      pll  = ($urandom_range(0, 99) != 0);
      dl   = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 29) == 0) init = ~init;
      if (key_len > 0) begin
        key = 1'b0;
        key_len--;
      end else begin
        key = 1'b1;
        if ($urandom_range(0, 39) == 0) key_len = $urandom_range(1, 12);
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
